wb_regfile: RTL and testbench

Writeback stage plus architectural register file: consumes the MEM/WB pipeline register outputs, selects memory read data or ALU result, and commits it to a 32 × 32-bit register file. Supplies the two combinational read ports used by ID, and exports the selected writeback value and destination to the forwarding unit. It is the consuming end of the MEM/WB interface.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/wb_select.sv | 35 +++
 rtl/wb_regfile.sv | 93 +++++++++
 tb/tb_wb_regfile.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline constants: datapath width, register file geometry and the
// layout of the MEM/WB writeback control field.
package cpu_pkg;
  localparam int DATA_W          = 32;
  localparam int NREGS           = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;
endpackage : cpu_pkg

// File: rtl/wb_select.sv
// Writeback source mux and write-enable qualification (purely combinational).
module wb_select
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [1:0]            wb,
  input  logic [DATA_W-1:0]     read_data,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_reg,
  output logic                  wb_en
);

  logic wb_en_s;

  // Select writeback source; a write to r0 is never an effective write.
  always_comb begin
    if (wb[WB_MEMTOREG_BIT]) begin
      wb_data = read_data;
    end else begin
      wb_data = alu_result;
    end
    wb_en_s = wb[WB_REGWRITE_BIT] && (write_reg != {REG_ADDR_W{1'b0}});
    if (wb_en_s) begin
      wb_reg = write_reg;
    end else begin
      wb_reg = {REG_ADDR_W{1'b0}};
    end
  end

  assign wb_en = wb_en_s;

endmodule : wb_select

// File: rtl/wb_regfile.sv
// Writeback stage plus 32x32 architectural register file with two async read ports.
// Optional same-cycle write-through on reads is enabled by macro REGFILE_BYPASS_EN.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            WB_in,
  input  logic [DATA_W-1:0]     ReadData_in,
  input  logic [DATA_W-1:0]     ALUResult_in,
  input  logic [REG_ADDR_W-1:0] WriteReg_in,
  input  logic [REG_ADDR_W-1:0] ReadReg1,
  input  logic [REG_ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]     ReadData1,
  output logic [DATA_W-1:0]     ReadData2,
  output logic [DATA_W-1:0]     WBData,
  output logic [REG_ADDR_W-1:0] WBReg,
  output logic                  WBEn,
  output logic [31:0]           WBCount
);

  logic [DATA_W-1:0]     regs_r [NREGS];
  logic [31:0]           wb_count_r;
  logic [DATA_W-1:0]     wb_data_s;
  logic [REG_ADDR_W-1:0] wb_reg_s;
  logic                  wb_en_s;
  logic [DATA_W-1:0]     rd1_s;
  logic [DATA_W-1:0]     rd2_s;

  wb_select #(.DATA_W(DATA_W)) u_wb_select (
    .wb        (WB_in),
    .read_data (ReadData_in),
    .alu_result(ALUResult_in),
    .write_reg (WriteReg_in),
    .wb_data   (wb_data_s),
    .wb_reg    (wb_reg_s),
    .wb_en     (wb_en_s)
  );

  // Commit the selected value; r0 is excluded because wb_en_s is never set for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en_s) begin
      regs_r[WriteReg_in] <= wb_data_s;
    end
  end

  // Committed-write counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_r <= 32'd0;
    end else if (wb_en_s) begin
      wb_count_r <= wb_count_r + 32'd1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     stored
  );
    logic [DATA_W-1:0] value;
    if (addr == {REG_ADDR_W{1'b0}}) begin
      value = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
    end else if (wb_en_s && (addr == WriteReg_in)) begin
      value = wb_data_s;
`endif
    end else begin
      value = stored;
    end
    return value;
  endfunction

  // Asynchronous read ports.
  always_comb begin
    rd1_s = read_port(ReadReg1, regs_r[ReadReg1]);
    rd2_s = read_port(ReadReg2, regs_r[ReadReg2]);
  end

  assign ReadData1 = rd1_s;
  assign ReadData2 = rd2_s;
  assign WBData    = wb_data_s;
  assign WBReg     = wb_reg_s;
  assign WBEn      = wb_en_s;
  assign WBCount   = wb_count_r;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile; expectations follow REGFILE_BYPASS_EN.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [1:0]  WB_in;
  logic [31:0] ReadData_in;
  logic [31:0] ALUResult_in;
  logic [4:0]  WriteReg_in;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WBData;
  logic [4:0]  WBReg;
  logic        WBEn;
  logic [31:0] WBCount;

  int checks;
  int errors;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  wb_regfile dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .WB_in       (WB_in),
    .ReadData_in (ReadData_in),
    .ALUResult_in(ALUResult_in),
    .WriteReg_in (WriteReg_in),
    .ReadReg1    (ReadReg1),
    .ReadReg2    (ReadReg2),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .WBData      (WBData),
    .WBReg       (WBReg),
    .WBEn        (WBEn),
    .WBCount     (WBCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_item_t it;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    WB_in        = wb;
    ReadData_in  = rd;
    ALUResult_in = alu;
    WriteReg_in  = wr;
    ReadReg1     = r1;
    ReadReg2     = r2;
    #1;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    WB_in = 2'b10; ReadData_in = 32'h0; ALUResult_in = 32'h0000_00AA;
    WriteReg_in = 5'd5; ReadReg1 = 5'd5; ReadReg2 = 5'd0;

    // Reset: combinational outputs follow inputs, state stays zero
    #2;
    push("rst_rd1", 32'h0);  push("rst_count", 32'h0);
    push("rst_wbdata", 32'h0000_00AA); push("rst_wben", 32'h1); push("rst_wbreg", 32'h5);
    pop_check(ReadData1); pop_check(WBCount);
    pop_check(WBData); pop_check({31'd0, WBEn}); pop_check({27'd0, WBReg});
    post_edge();
    post_edge();
    push("rst_write_discarded", 32'h0); push("rst_count_held", 32'h0);
    pop_check(ReadData1); pop_check(WBCount);
    @(negedge clk);
    rst_n = 1'b1;
    WB_in = 2'b00;
    #1;
    push("rst_release_r5", 32'h0);
    pop_check(ReadData1);

    // ALU write to r7
    drive(2'b10, 32'h0, 32'h1234_5678, 5'd7, 5'd7, 5'd0);
    push("alu_wbdata", 32'h1234_5678); push("alu_wbreg", 32'h7);
    pop_check(WBData); pop_check({27'd0, WBReg});
    post_edge();
    drive(2'b00, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
    push("alu_r7_p1", 32'h1234_5678); push("alu_r7_p2", 32'h1234_5678); push("alu_count", 32'h1);
    pop_check(ReadData1); pop_check(ReadData2); pop_check(WBCount);

    // Load write to r31
    drive(2'b11, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31, 5'd0, 5'd31);
    push("load_wbdata", 32'hDEAD_BEEF);
    pop_check(WBData);
    post_edge();
    push("load_r31", 32'hDEAD_BEEF); push("load_count", 32'h2);
    pop_check(ReadData2); pop_check(WBCount);

    // r0 protection
    drive(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd7, 5'd0);
    push("r0_wben", 32'h0); push("r0_wbreg", 32'h0);
    pop_check({31'd0, WBEn}); pop_check({27'd0, WBReg});
    post_edge();
    push("r0_read", 32'h0); push("r0_count", 32'h2); push("r0_r7_intact", 32'h1234_5678);
    pop_check(ReadData2); pop_check(WBCount); pop_check(ReadData1);

    // No-write: r3 keeps its earlier value
    drive(2'b10, 32'h0, 32'h0000_0033, 5'd3, 5'd0, 5'd0);
    post_edge();
    drive(2'b01, 32'h0000_0055, 32'h0000_0066, 5'd3, 5'd3, 5'd0);
    push("nowr_wbdata", 32'h0000_0055); push("nowr_wben", 32'h0); push("nowr_wbreg", 32'h0);
    pop_check(WBData); pop_check({31'd0, WBEn}); pop_check({27'd0, WBReg});
    post_edge();
    push("nowr_r3", 32'h0000_0033); push("nowr_count", 32'h3);
    pop_check(ReadData1); pop_check(WBCount);

    // Same-cycle hazard on r4
    drive(2'b10, 32'h0, 32'h0000_0010, 5'd4, 5'd0, 5'd0);
    post_edge();
    drive(2'b10, 32'h0, 32'h0000_0020, 5'd4, 5'd4, 5'd4);
`ifdef REGFILE_BYPASS_EN
    push("hazard_pre_p1", 32'h0000_0020); push("hazard_pre_p2", 32'h0000_0020);
`else
    push("hazard_pre_p1", 32'h0000_0010); push("hazard_pre_p2", 32'h0000_0010);
`endif
    pop_check(ReadData1); pop_check(ReadData2);
    post_edge();
    WB_in = 2'b00;
    #1;
    push("hazard_post_p1", 32'h0000_0020); push("hazard_post_p2", 32'h0000_0020);
    push("hazard_count", 32'h5);
    pop_check(ReadData1); pop_check(ReadData2); pop_check(WBCount);

    // Mid-run async reset after writing r5
    drive(2'b10, 32'h0, 32'h0000_5555, 5'd5, 5'd5, 5'd4);
    post_edge();
    WB_in = 2'b00;
    #1;
    push("pre_rst_r5", 32'h0000_5555); push("pre_rst_count", 32'h6);
    pop_check(ReadData1); pop_check(WBCount);
    #2;
    rst_n = 1'b0;
    #1;
    push("midrst_r5", 32'h0); push("midrst_r4", 32'h0); push("midrst_count", 32'h0);
    pop_check(ReadData1); pop_check(ReadData2); pop_check(WBCount);
    @(negedge clk);
    rst_n = 1'b1;

    // Count restarts after reset
    drive(2'b11, 32'h0000_0077, 32'h0, 5'd9, 5'd9, 5'd0);
    post_edge();
    push("after_rst_r9", 32'h0000_0077); push("after_rst_count", 32'h1);
    pop_check(ReadData1); pop_check(WBCount);

    checks++;
    assert (sb_q.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_regfile
